// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types for the pipeline stall controller slice.
//   stall_pipeline_sig : encoding of the hazard detector's load-use stall request
//   ctrl_state_t       : controller FSM states
//   FLUSH_CNT_W        : width of the flush sequencing counter (FLUSH_CYCLES <= 15)
package pipeline_stall_controller_pkg;

  typedef enum logic {
    NO_STALL_PIPELINE = 1'b0,
    STALL_PIPELINE    = 1'b1
  } stall_pipeline_sig;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } ctrl_state_t;

  localparam int unsigned FLUSH_CNT_W = 4;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
// Ports:
//   clk_i   in  clock
//   rst_i   in  synchronous active-high reset (count -> 0)
//   clr_i   in  clear to 0 (wins over inc_i)
//   inc_i   in  increment by one, holds at all-ones
//   count_o out current count
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: arbitrates hazard-detector stall/invalidate
// requests against EXE branch redirects and drives the PC, IF/ID and ID/EXE
// register controls. Priority per cycle: branch > stall > run. A redirect
// squashes IF/ID for FLUSH_CYCLES cycles (redirect cycle included); stall
// requests are ignored while flushing. A watchdog flags stalls that last
// MAX_STALL_CYCLES consecutive cycles (sticky until reset).
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   stall_pipeline_i              load-use stall request
//   hazard_detector_invalidate_i  bubble request for ID/EXE
//   branch_taken_EXE_i            taken branch resolved in EXE
//   pc_write_en_o, pc_sel_branch_o, if_id_write_en_o, if_id_flush_o,
//   id_exe_bubble_o               pipeline register controls (same-cycle)
//   stall_cycles_o                consecutive stall cycles, saturating
//   stall_timeout_o               sticky stall watchdog flag
// Optional build macro STALL_PERF_CNT_EN adds stall_total_o / flush_total_o
// (32-bit wrapping counts of applied stall cycles and branch redirects).
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES     = 2,
  parameter int unsigned MAX_STALL_CYCLES = 4,
  parameter int unsigned CNT_WIDTH        = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  stall_pipeline_sig    stall_pipeline_i,
  input  logic                 hazard_detector_invalidate_i,
  input  logic                 branch_taken_EXE_i,
  output logic                 pc_write_en_o,
  output logic                 pc_sel_branch_o,
  output logic                 if_id_write_en_o,
  output logic                 if_id_flush_o,
  output logic                 id_exe_bubble_o,
  output logic [CNT_WIDTH-1:0] stall_cycles_o,
  output logic                 stall_timeout_o
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0]          stall_total_o,
  output logic [31:0]          flush_total_o
`endif
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  // Watchdog fires on the cycle whose increment brings the count to the limit.
  localparam logic [CNT_WIDTH:0]     TIMEOUT_AT   = (CNT_WIDTH + 1)'(MAX_STALL_CYCLES - 1);

  ctrl_state_t            state_q;
  ctrl_state_t            state_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q;
  logic [FLUSH_CNT_W-1:0] flush_cnt_d;
  logic                   timeout_q;
  logic                   timeout_d;
  logic                   stall_applied;
  logic                   branch_applied;

  always_comb begin
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    stall_applied    = 1'b0;
    branch_applied   = 1'b0;
    pc_write_en_o    = 1'b1;
    pc_sel_branch_o  = 1'b0;
    if_id_write_en_o = 1'b1;
    if_id_flush_o    = 1'b0;
    id_exe_bubble_o  = hazard_detector_invalidate_i;

    if (rst_i) begin
      pc_write_en_o    = 1'b0;
      if_id_write_en_o = 1'b0;
      if_id_flush_o    = 1'b1;
      id_exe_bubble_o  = 1'b1;
      state_d          = RUN;
      flush_cnt_d      = '0;
    end else if (branch_taken_EXE_i) begin
      branch_applied   = 1'b1;
      pc_sel_branch_o  = 1'b1;
      if_id_flush_o    = 1'b1;
      id_exe_bubble_o  = 1'b1;
      flush_cnt_d      = FLUSH_RELOAD;
      state_d          = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else if (state_q == FLUSH) begin
      if_id_flush_o    = 1'b1;
      id_exe_bubble_o  = 1'b1;
      flush_cnt_d      = flush_cnt_q - FLUSH_CNT_W'(1);
      if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
        state_d = RUN;
      end
    end else if (stall_pipeline_i == STALL_PIPELINE) begin
      stall_applied    = 1'b1;
      pc_write_en_o    = 1'b0;
      if_id_write_en_o = 1'b0;
      id_exe_bubble_o  = 1'b1;
      state_d          = STALL;
    end else begin
      state_d = RUN;
    end
  end

  always_comb begin
    timeout_d = timeout_q;
    if (stall_applied && ({1'b0, stall_cycles_o} >= TIMEOUT_AT)) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign stall_timeout_o = timeout_q;

  // Any cycle without an applied stall ends the consecutive run; this covers
  // both the STALL->RUN drop and the clear on a branch redirect.
  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (!stall_applied),
    .inc_i  (stall_applied),
    .count_o(stall_cycles_o)
  );

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_total_q;
  logic [31:0] flush_total_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_total_q <= '0;
      flush_total_q <= '0;
    end else begin
      stall_total_q <= stall_total_q + {31'd0, stall_applied};
      flush_total_q <= flush_total_q + {31'd0, branch_applied};
    end
  end

  assign stall_total_o = stall_total_q;
  assign flush_total_o = flush_total_q;
`endif

endmodule
